// File: rtl/layer_out_serializer_pkg.sv
// Shared types and sizing constants for the layer output serializer.
// Each layer's neuron count lives here so every instance can size itself from one place.
package layer_out_serializer_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    // Neuron count of each producing layer, input side first.
    localparam int LAYER_NEURONS [3] = '{30, 30, 10};

    typedef enum logic {
        IDLE,
        SHIFT
    } shift_state_t;

endpackage

// File: rtl/layer_out_serializer_if.sv
// Bundles the parallel neuron-output bus and the serial next-layer bus.
// The master drives neuron outputs; the slave (serializer) drives the serial side.
interface layer_out_serializer_if
    import layer_out_serializer_pkg::*;
#(
    parameter int NUM_NEURONS = LAYER_NEURONS[0],
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
);

    logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
    logic [NUM_NEURONS-1:0]            in_valid;
    logic [DATA_WIDTH-1:0]             out_data;
    logic                              out_valid;
    logic                              busy;
    logic                              overrun;

    modport master (
        output in_data,
        output in_valid,
        input  out_data,
        input  out_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output out_data,
        output out_valid,
        output busy,
        output overrun
    );

endinterface

// File: rtl/layer_out_collector.sv
// Gathers one word per neuron into a holding register, tracking which neurons have reported.
// Flags a complete set, holds it as pending while the shifter is busy, and latches overrun.
module layer_out_collector
    import layer_out_serializer_pkg::*;
#(
    parameter int NUM_NEURONS = LAYER_NEURONS[0],
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_NEURONS-1:0]            in_valid,
    input  logic                              can_load,
    output logic                              complete,
    output logic                              pending,
    output logic                              overrun,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] collected
);

    logic [NUM_NEURONS-1:0]            mask;
    logic [NUM_NEURONS-1:0]            mask_nxt;
    logic [NUM_NEURONS-1:0]            fire;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] coll_p0;
    logic                              pending_nxt;
    logic                              collide;

    // Same-edge captures are merged in so a completing word reaches the shifter without delay.
    always_comb begin
        fire        = in_valid & ~mask;
        collide     = |(in_valid & mask);
        mask_nxt    = mask | in_valid;
        complete    = &mask_nxt;
        pending_nxt = complete & ~can_load;
        collected   = coll_p0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (fire[i]) begin
                collected[i*DATA_WIDTH +: DATA_WIDTH] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---- stage p0: capture registers ----
    always_ff @(posedge clk) begin
        coll_p0 <= collected;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask    <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            mask    <= (complete && can_load) ? '0 : mask_nxt;
            pending <= pending_nxt;
            if (collide) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_out_serializer.sv
// Serializes a complete set of neuron outputs into a gapless one-word-per-cycle burst,
// neuron 0 first, with back-to-back bursts when the next set is already waiting.
module layer_out_serializer
    import layer_out_serializer_pkg::*;
#(
    parameter int NUM_NEURONS = LAYER_NEURONS[0],
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    layer_out_serializer_if.slave bus
);

    localparam int              CNT_W = $clog2(NUM_NEURONS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NEURONS - 1);

    shift_state_t                      state;
    logic [CNT_W-1:0]                  cnt;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] shreg_p1;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] collected;
    logic [DATA_WIDTH-1:0]             data_p1;
    logic                              vld_p1;
    logic                              complete;
    logic                              pending;
    logic                              overrun;
    logic                              last_beat;
    logic                              can_load;
    logic                              load;

    assign last_beat = (state == SHIFT) && (cnt == LAST);
    assign can_load  = (state == IDLE) || last_beat;
    assign load      = complete && can_load;

    layer_out_collector #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_collector (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bus.in_data),
        .in_valid  (bus.in_valid),
        .can_load  (can_load),
        .complete  (complete),
        .pending   (pending),
        .overrun   (overrun),
        .collected (collected)
    );

    // ---- stage p1: shift register and output word ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            if (load) begin
                state    <= SHIFT;
                cnt      <= '0;
                data_p1  <= collected[DATA_WIDTH-1:0];
                shreg_p1 <= collected >> DATA_WIDTH;
                vld_p1   <= 1'b1;
            end else if (state == SHIFT && !last_beat) begin
                cnt      <= cnt + CNT_W'(1);
                data_p1  <= shreg_p1[DATA_WIDTH-1:0];
                shreg_p1 <= shreg_p1 >> DATA_WIDTH;
                vld_p1   <= 1'b1;
            end else begin
                state  <= IDLE;
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_p1;
    assign bus.out_valid = vld_p1;
    assign bus.busy      = (state == SHIFT) || pending;
    assign bus.overrun   = overrun;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with four 16-bit neurons.
module tb_layer_out_serializer;

    localparam int N  = 4;
    localparam int DW = 16;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    layer_out_serializer_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) bus ();

    layer_out_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [DW-1:0] w);
        bus.in_data[i*DW +: DW] = w;
        bus.in_valid[i]         = 1'b1;
    endtask

    task automatic clr();
        bus.in_valid = '0;
    endtask

    task automatic put_set(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        put(0, w0);
        put(1, w1);
        put(2, w2);
        put(3, w3);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts on the first beat's cycle and ends on the last beat's cycle.
    task automatic chk_burst(input string tag, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        logic [DW-1:0] w [4];
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        w[3] = w3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_vld%0d", tag, k), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("%s_dat%0d", tag, k), {16'd0, bus.out_data}, {16'd0, w[k]});
            if (k < 3) step();
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        bus.in_data  = '0;
        bus.in_valid = '0;
        rst          = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_vld",  {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", {16'd0, bus.out_data},  32'd0);
        chk("rst_busy", {31'd0, bus.busy},      32'd0);
        chk("rst_ovr",  {31'd0, bus.overrun},   32'd0);

        // All neurons fire together.
        put_set(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        step();
        clr();
        chk("full_busy", {31'd0, bus.busy}, 32'd1);
        chk_burst("full", 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        step();
        chk("full_end_vld",  {31'd0, bus.out_valid}, 32'd0);
        chk("full_end_busy", {31'd0, bus.busy},      32'd0);
        chk("full_end_ovr",  {31'd0, bus.overrun},   32'd0);

        // Staggered: n2 at c0, n0 at c3, n3 at c5, n1 at c9.
        for (int c = 0; c < 10; c++) begin
            if (c == 0) put(2, 16'h0303);
            if (c == 3) put(0, 16'h0101);
            if (c == 5) put(3, 16'h0404);
            if (c == 9) put(1, 16'h0202);
            step();
            clr();
            if (c < 9) chk($sformatf("stag_quiet%0d", c), {31'd0, bus.out_valid}, 32'd0);
        end
        chk_burst("stag", 16'h0101, 16'h0202, 16'h0303, 16'h0404);
        step();
        chk("stag_end_vld", {31'd0, bus.out_valid}, 32'd0);

        // Second set completes during the first burst and waits as pending.
        put_set(16'hA001, 16'hA002, 16'hA003, 16'hA004);
        step();
        clr();
        chk("b2b_d0", {16'd0, bus.out_data}, 32'h0000A001);
        put_set(16'hB001, 16'hB002, 16'hB003, 16'hB004);
        step();
        clr();
        chk("b2b_d1",      {16'd0, bus.out_data}, 32'h0000A002);
        chk("b2b_pending", {31'd0, bus.busy},     32'd1);
        step();
        chk("b2b_d2", {16'd0, bus.out_data}, 32'h0000A003);
        step();
        chk("b2b_d3", {16'd0, bus.out_data}, 32'h0000A004);
        step();
        chk("b2b_busy2", {31'd0, bus.busy}, 32'd1);
        chk_burst("b2b_2nd", 16'hB001, 16'hB002, 16'hB003, 16'hB004);
        step();
        chk("b2b_end_vld",  {31'd0, bus.out_valid}, 32'd0);
        chk("b2b_end_busy", {31'd0, bus.busy},      32'd0);
        chk("b2b_end_ovr",  {31'd0, bus.overrun},   32'd0);

        // Neuron 1 fires twice before the set completes.
        put(1, 16'h00AA);
        step();
        clr();
        chk("ovr_pre", {31'd0, bus.overrun}, 32'd0);
        put(1, 16'h00BB);
        step();
        clr();
        chk("ovr_set", {31'd0, bus.overrun},   32'd1);
        chk("ovr_vld", {31'd0, bus.out_valid}, 32'd0);
        put(0, 16'h0C00);
        put(2, 16'h0C02);
        put(3, 16'h0C03);
        step();
        clr();
        chk_burst("ovr", 16'h0C00, 16'h00AA, 16'h0C02, 16'h0C03);
        step();
        chk("ovr_sticky", {31'd0, bus.overrun},   32'd1);
        chk("ovr_end_vld", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a burst, with a partial next set captured.
        put_set(16'h5000, 16'h5001, 16'h5002, 16'h5003);
        step();
        clr();
        chk("rmid_d0", {16'd0, bus.out_data}, 32'h00005000);
        step();
        chk("rmid_d1", {16'd0, bus.out_data}, 32'h00005001);
        put(0, 16'hDEAD);
        rst = 1'b1;
        step();
        clr();
        rst = 1'b0;
        chk("rmid_vld",  {31'd0, bus.out_valid}, 32'd0);
        chk("rmid_busy", {31'd0, bus.busy},      32'd0);
        chk("rmid_ovr",  {31'd0, bus.overrun},   32'd0);
        put(1, 16'h5101);
        put(2, 16'h5102);
        put(3, 16'h5103);
        step();
        clr();
        chk("rmid_mask_clr", {31'd0, bus.out_valid}, 32'd0);
        chk("rmid_idle",     {31'd0, bus.busy},      32'd0);
        put(0, 16'h5100);
        step();
        clr();
        chk_burst("rmid_fresh", 16'h5100, 16'h5101, 16'h5102, 16'h5103);
        step();
        chk("rmid_end_vld", {31'd0, bus.out_valid}, 32'd0);

        // Set completes on the same edge as the last beat.
        put_set(16'h6000, 16'h6001, 16'h6002, 16'h6003);
        step();
        clr();
        chk_burst("edge_1st", 16'h6000, 16'h6001, 16'h6002, 16'h6003);
        put_set(16'h7000, 16'h7001, 16'h7002, 16'h7003);
        step();
        clr();
        chk_burst("edge_2nd", 16'h7000, 16'h7001, 16'h7002, 16'h7003);
        step();
        chk("edge_end_vld",  {31'd0, bus.out_valid}, 32'd0);
        chk("edge_end_busy", {31'd0, bus.busy},      32'd0);
        chk("edge_end_ovr",  {31'd0, bus.overrun},   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
